// File: rtl/permute_pi_stage.sv
// Keccak pi lane permutation over a stream of 25-bit z-slices, with a per-run
// controller that strobes each permuted slice straight into the result writer.
module permute_pi_stage #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned IDX_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] file_index_in,
  input  logic             in_valid,
  input  logic [24:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             write_file,
  output logic [IDX_W-1:0] file_index,
  output logic [24:0]      data_out,
  output logic             done,
  output logic [CNT_W-1:0] slice_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept_c;
  logic        last_c;
  logic [24:0] pi_c;

  assign accept_c = in_valid && (state == RUN);
  assign last_c   = (slice_cnt == CNT_W'(SLICES - 1));

  // pi as pure wiring: out lane (x,y) takes in lane ((x+3y) mod 5, x)
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_lane
      assign pi_c[5*y + x] = in_data[5*x + ((x + 3*y) % 5)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept_c && last_c) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobe trails the accept by one cycle; the last one lands in FLUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      write_file <= 1'b0;
      file_index <= '0;
      data_out   <= '0;
      slice_cnt  <= '0;
    end else begin
      write_file <= accept_c;
      if (state == IDLE && start) begin
        file_index <= file_index_in;
        slice_cnt  <= '0;
      end
      if (accept_c) begin
        data_out  <= pi_c;
        slice_cnt <= slice_cnt + CNT_W'(1);
      end
    end
  end

endmodule
